// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing scheduler: opcodes, FSM encoding,
// default parameters and the EXEC hold-count helper.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam int WIDTH_DEF      = 32;
    // Multiply needs the ALU inputs held this many cycles; legal range 1..15.
    localparam int MUL_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Extra EXEC cycles beyond the first: multiply holds for MUL_CYCLES cycles,
    // every other opcode (including unsupported ones) completes in one.
    function automatic logic [3:0] hold_count(input logic [2:0] ctrl, input int mul_cycles);
        logic [3:0] cnt;
        cnt = 4'd0;
        if (ctrl == ALU_MUL) begin
            cnt = 4'(mul_cycles - 1);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/alu_share_sched_rr_arbiter2.sv
// Two-way round-robin arbiter. last_grant is the id granted most recently;
// on a tie the other requester wins. A lone request wins regardless.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] grant
);

    // Grant is purely combinational so the winner sees ready in the same cycle.
    always_comb begin
        grant    = 2'b00;
        grant[0] = en & req[0] & (~req[1] | last_grant);
        grant[1] = en & req[1] & (~req[0] | ~last_grant);
    end

endmodule

// File: rtl/alu_share_sched.sv
// Shares one external combinational ALU between two requesters.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Requesters hold valid/operands until ready (dropping valid early is legal
// and transfers nothing). The response is held stable while resp_valid is high
// and resp_ready is low.
module alu_share_sched
    import alu_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic [1:0]       state_dbg
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             id_q, id_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic             resp_id_q, resp_id_d;
    logic             last_grant_q, last_grant_d;

    logic             arb_en;
    logic [1:0]       grant;

    // Arbitration only runs in IDLE and is suppressed while reset is held,
    // so no requester sees ready during reset.
    assign arb_en = (state_q == S_IDLE) && !reset;

    rr_arbiter2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .en         (arb_en),
        .grant      (grant)
    );

    // Next-state and register-load logic for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        ctrl_d        = ctrl_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        resp_result_d = resp_result_q;
        resp_id_d     = resp_id_q;
        last_grant_d  = last_grant_q;

        case (state_q)
            S_IDLE: begin
                if (grant[0]) begin
                    a_d          = req0_a;
                    b_d          = req0_b;
                    ctrl_d       = req0_ctrl;
                    id_d         = 1'b0;
                    cnt_d        = hold_count(req0_ctrl, MUL_CYCLES);
                    last_grant_d = 1'b0;
                    state_d      = S_EXEC;
                end else if (grant[1]) begin
                    a_d          = req1_a;
                    b_d          = req1_b;
                    ctrl_d       = req1_ctrl;
                    id_d         = 1'b1;
                    cnt_d        = hold_count(req1_ctrl, MUL_CYCLES);
                    last_grant_d = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    resp_result_d = alu_result;
                    resp_id_d     = id_q;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            ctrl_q        <= 3'b000;
            id_q          <= 1'b0;
            cnt_q         <= 4'd0;
            resp_result_q <= '0;
            resp_id_q     <= 1'b0;
            last_grant_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            ctrl_q        <= ctrl_d;
            id_q          <= id_d;
            cnt_q         <= cnt_d;
            resp_result_q <= resp_result_d;
            resp_id_q     <= resp_id_d;
            last_grant_q  <= last_grant_d;
        end
    end

    // ALU inputs always come from the operand registers, so they stay quiet
    // outside EXEC instead of following the request buses.
    always_comb begin
        req0_ready  = grant[0];
        req1_ready  = grant[1];
        alu_a       = a_q;
        alu_b       = b_q;
        alu_ctrl    = ctrl_q;
        resp_valid  = (state_q == S_RESP);
        resp_id     = resp_id_q;
        resp_result = resp_result_q;
        state_dbg   = state_q;
    end

endmodule
